// File: rtl/seq_combo_lock.sv
// seq_combo_lock: multi-stage one-hot keypad combination lock with fail lockout and override.
// Define COMBO_LOCK_PROG_EN to add a combination register that is writable while the lock is open.
module seq_combo_lock #(
  parameter int unsigned                 DIGITS         = 4,
  parameter int unsigned                 STAGES         = 3,
  parameter logic [STAGES*DIGITS*4-1:0]  COMBO          = 48'h2730_0000_2730,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 16,
  parameter int unsigned                 OPEN_CYCLES    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIGITS*10-1:0]               digits,
  input  logic                               digits_valid,
  input  logic                               override,
`ifdef COMBO_LOCK_PROG_EN
  input  logic                               prog_we,
  input  logic [STAGES*DIGITS*4-1:0]         prog_combo,
`endif
  output logic                               open,
  output logic                               locked_out,
  output logic [$clog2(STAGES+1)-1:0]        stage,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

  localparam int unsigned COMBO_W = STAGES * DIGITS * 4;
  localparam int unsigned STAGE_W = $clog2(STAGES + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX    = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  logic [1:0]         state, state_d;
  logic [STAGE_W-1:0] stage_d;
  logic [FAIL_W-1:0]  fail_d, fail_inc;
  logic [TIMER_W-1:0] timer, timer_d, timer_inc;
  logic [COMBO_W-1:0] combo;
  logic [9:0]         want;
  logic               entry_ok_c;

`ifdef COMBO_LOCK_PROG_EN
  // Stored combination; only rewritable while the lock is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) combo <= COMBO;
    else if (prog_we && open) combo <= prog_combo;
  end
`else
  assign combo = COMBO;
`endif

  // Each field must equal the one-hot image of the expected digit; non-decimal digits never match.
  always_comb begin
    entry_ok_c = 1'b1;
    want       = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      want = 10'(1) << combo[(32'(stage) * DIGITS + d) * 4 +: 4];
      if ((digits[d*10 +: 10] != want) || (want == '0)) entry_ok_c = 1'b0;
    end
  end

  assign fail_inc  = fail_cnt + FAIL_W'(1);
  assign timer_inc = (timer == TIMER_W'(TMAX)) ? timer : timer + TIMER_W'(1);

  always_comb begin
    state_d = state;
    stage_d = stage;
    fail_d  = fail_cnt;
    timer_d = timer;
    if (override) begin
      state_d = OPEN;
      stage_d = '0;
      fail_d  = '0;
      timer_d = '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (digits_valid) begin
            if (entry_ok_c) begin
              if (stage == STAGE_W'(STAGES - 1)) begin
                state_d = OPEN;
                stage_d = '0;
                fail_d  = '0;
                timer_d = '0;
              end else begin
                state_d = COLLECT;
                stage_d = stage + STAGE_W'(1);
              end
            end else begin
              // A wrong entry only restarts; it is not re-checked against stage 0.
              stage_d = '0;
              fail_d  = fail_inc;
              timer_d = '0;
              state_d = (fail_inc == FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
            end
          end
        end
        OPEN: begin
          if (timer == TIMER_W'(OPEN_CYCLES - 1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        LOCKOUT: begin
          if (timer == TIMER_W'(LOCKOUT_CYCLES - 1)) begin
            state_d = IDLE;
            timer_d = '0;
            fail_d  = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      stage      <= '0;
      fail_cnt   <= '0;
      timer      <= '0;
      open       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_d;
      stage      <= stage_d;
      fail_cnt   <= fail_d;
      timer      <= timer_d;
      open       <= (state_d == OPEN);
      locked_out <= (state_d == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_seq_combo_lock.sv
// tb_seq_combo_lock: directed and randomized checks of seq_combo_lock against a countdown-based reference model.
module tb_seq_combo_lock;

  localparam int DIGITS         = 4;
  localparam int STAGES         = 3;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int OPEN_CYCLES    = 8;
  localparam int DW             = DIGITS * 10;
  localparam int CW             = STAGES * DIGITS * 4;
  localparam int SW             = $clog2(STAGES + 1);
  localparam int FW             = $clog2(MAX_FAILS + 1);
  localparam logic [CW-1:0] DEF_COMBO = 48'h2730_0000_2730;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] digits = '0;
  logic          digits_valid = 1'b0;
  logic          override = 1'b0;
  logic          open;
  logic          locked_out;
  logic [SW-1:0] stage;
  logic [FW-1:0] fail_cnt;
`ifdef COMBO_LOCK_PROG_EN
  logic          prog_we = 1'b0;
  logic [CW-1:0] prog_combo = '0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining-cycle countdowns, attempt progress, and the combination as digit values.
  int m_open_left, m_lock_left, m_progress, m_fails;
  int m_combo[STAGES][DIGITS];

  seq_combo_lock #(
    .DIGITS(DIGITS), .STAGES(STAGES), .COMBO(DEF_COMBO), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .OPEN_CYCLES(OPEN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits(digits),
    .digits_valid(digits_valid),
    .override(override),
`ifdef COMBO_LOCK_PROG_EN
    .prog_we(prog_we),
    .prog_combo(prog_combo),
`endif
    .open(open),
    .locked_out(locked_out),
    .stage(stage),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] enc(logic [15:0] bcd);
    logic [DW-1:0] v;
    v = '0;
    for (int d = 0; d < DIGITS; d++) v[d*10 + int'(bcd[d*4 +: 4])] = 1'b1;
    return v;
  endfunction

  function automatic bit entry_ok(logic [DW-1:0] dg, int s);
    for (int d = 0; d < DIGITS; d++) begin
      int hits, val;
      hits = 0;
      val  = -1;
      for (int k = 0; k < 10; k++) if (dg[d*10 + k]) begin hits++; val = k; end
      if (hits != 1 || val != m_combo[s][d]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    logic [CW-1:0] c;
    c = DEF_COMBO;
    m_open_left = 0; m_lock_left = 0; m_progress = 0; m_fails = 0;
    for (int s = 0; s < STAGES; s++)
      for (int d = 0; d < DIGITS; d++) m_combo[s][d] = int'(c[(s*DIGITS + d)*4 +: 4]);
  endtask

  task automatic model_step();
`ifdef COMBO_LOCK_PROG_EN
    if (prog_we && m_open_left > 0)
      for (int s = 0; s < STAGES; s++)
        for (int d = 0; d < DIGITS; d++) m_combo[s][d] = int'(prog_combo[(s*DIGITS + d)*4 +: 4]);
`endif
    if (override) begin
      m_open_left = OPEN_CYCLES; m_lock_left = 0; m_progress = 0; m_fails = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (digits_valid) begin
      if (entry_ok(digits, m_progress)) begin
        if (m_progress == STAGES - 1) begin
          m_open_left = OPEN_CYCLES; m_progress = 0; m_fails = 0;
        end else begin
          m_progress++;
        end
      end else begin
        m_progress = 0;
        m_fails++;
        if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".open"},       32'(open),       32'(m_open_left > 0));
    check({tag, ".locked_out"}, 32'(locked_out), 32'(m_lock_left > 0));
    check({tag, ".stage"},      32'(stage),      32'(m_progress));
    check({tag, ".fail_cnt"},   32'(fail_cnt),   32'(m_fails));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic entry(logic [DW-1:0] v);
    digits = v;
    digits_valid = 1'b1;
    step();
    digits_valid = 1'b0;
    digits = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    rst = 1'b1;
  endtask

  task automatic wait_open_low();
    for (int k = 0; k < 40 && open; k++) step();
    check("open_drop", 32'(open), 32'd0);
  endtask

  initial begin
    int n, r;
    logic [DW-1:0] v;
    logic [15:0] seq[3];
    seq[0] = 16'h2730; seq[1] = 16'h0000; seq[2] = 16'h2730;

    #12;
    do_reset();

    // Correct three-stage sequence opens for OPEN_CYCLES cycles.
    entry(enc(16'h2730)); check("seq_s1", 32'(stage), 32'd1); check_all("seq1");
    entry(enc(16'h0000)); check("seq_s2", 32'(stage), 32'd2); check_all("seq2");
    entry(enc(16'h2730)); check("open_rise", 32'(open), 32'd1); check_all("seq3");
    n = 1;
    for (int k = 0; k < 20 && open; k++) begin
      step(); check_all("open_hold");
      if (open) n++;
    end
    check("open_len", 32'(n), 32'd8);
    check("open_idle_stage", 32'(stage), 32'd0);

    // Wrong second entry restarts the attempt.
    do_reset();
    entry(enc(16'h2730)); check("wrong_s1", 32'(stage), 32'd1);
    entry(enc(16'h1111));
    check("wrong_stage", 32'(stage), 32'd0);
    check("wrong_fail", 32'(fail_cnt), 32'd1);
    check("wrong_open", 32'(open), 32'd0);
    check_all("wrong");

    // Multi-hot digit field counts as wrong.
    do_reset();
    v = enc(16'h2730);
    v[10 +: 10] = 10'b0000000101;
    entry(v);
    check("multihot_fail", 32'(fail_cnt), 32'd1);
    check("multihot_stage", 32'(stage), 32'd0);

    // Three wrong entries lock out; entries during lockout are ignored.
    do_reset();
    for (int k = 0; k < 3; k++) entry(enc(16'h1111));
    check("lock_rise", 32'(locked_out), 32'd1);
    check("lock_fail3", 32'(fail_cnt), 32'd3);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (k < 3) begin digits = enc(seq[k]); digits_valid = 1'b1; end
      else begin digits = '0; digits_valid = 1'b0; end
      step();
      check("lock_no_open", 32'(open), 32'd0);
      check_all("lock");
      if (locked_out) n++; else break;
    end
    digits_valid = 1'b0;
    check("lock_len", 32'(n), 32'd16);
    check("lock_fail_clr", 32'(fail_cnt), 32'd0);

    // Override escapes lockout; reset mid-open drops open immediately.
    do_reset();
    for (int k = 0; k < 3; k++) entry(enc(16'h1111));
    step(); step();
    override = 1'b1; step(); override = 1'b0;
    check("ovr_open", 32'(open), 32'd1);
    check("ovr_lock", 32'(locked_out), 32'd0);
    check("ovr_fail", 32'(fail_cnt), 32'd0);
    check_all("ovr");
    step(); step();
    check("pre_rst_open", 32'(open), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_open", 32'(open), 32'd0);
    check("rst_lock", 32'(locked_out), 32'd0);
    model_reset();
    check_all("rst_mid");
    rst = 1'b1;

    // Held override keeps restarting the open timer.
    override = 1'b1;
    for (int k = 0; k < 5; k++) step();
    override = 1'b0;
    for (int k = 0; k < 7; k++) begin step(); check("ovr_hold", 32'(open), 32'd1); end
    step();
    check("ovr_end", 32'(open), 32'd0);
    check_all("ovr_end");

`ifdef COMBO_LOCK_PROG_EN
    // Programming only takes effect while open.
    do_reset();
    prog_combo = 48'h1234_1234_1234;
    prog_we = 1'b1; step(); prog_we = 1'b0;
    entry(enc(16'h2730));
    check("prog_ignored", 32'(stage), 32'd1);
    do_reset();
    for (int k = 0; k < 3; k++) entry(enc(seq[k]));
    check("prog_open", 32'(open), 32'd1);
    prog_we = 1'b1; step(); prog_we = 1'b0;
    wait_open_low();
    for (int k = 0; k < 3; k++) entry(enc(16'h1234));
    check("prog_new_open", 32'(open), 32'd1);
    check_all("prog_new");
    wait_open_low();
    entry(enc(16'h2730)); check("prog_old_f1", 32'(fail_cnt), 32'd1);
    entry(enc(16'h0000)); check("prog_old_f2", 32'(fail_cnt), 32'd2);
    entry(enc(16'h2730));
    check("prog_old_open", 32'(open), 32'd0);
    check("prog_old_lock", 32'(locked_out), 32'd1);
    check_all("prog_old");
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else begin
        override     = ($urandom_range(0, 99) < 3);
        digits_valid = ($urandom_range(0, 99) < 60);
        r = $urandom_range(0, 3);
        v = '0;
        if (r < 2) begin
          for (int d = 0; d < DIGITS; d++) v[d*10 + m_combo[m_progress][d]] = 1'b1;
        end else if (r == 2) begin
          for (int d = 0; d < DIGITS; d++) v[d*10 + int'($urandom_range(0, 9))] = 1'b1;
        end else begin
          v = DW'({$urandom, $urandom});
        end
        digits = v;
`ifdef COMBO_LOCK_PROG_EN
        prog_we = ($urandom_range(0, 99) < 5);
        for (int k = 0; k < STAGES * DIGITS; k++) prog_combo[k*4 +: 4] = 4'($urandom_range(0, 9));
`endif
        step();
        check_all("rand");
      end
    end
    override = 1'b0;
    digits_valid = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
    prog_we = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
